vec_tx_8_16: RTL

VEC_TX_8_16 -- requirements
Module: vec_tx_8_16

---
 rtl/vec_tx_8_16_if.sv | 34 +++
 rtl/vec_tx_8_16.sv | 77 +++++++
 2 files changed

// File: rtl/vec_tx_8_16_if.sv
// Handshake bundle for vec_tx_8_16: vector load side and element output side.
// The slave modport is the transmitter's view; master is the driver/consumer view.
interface vec_tx_8_16_if #(
    parameter int T = 16,
    parameter int N = 8
);
    logic                  load_valid;
    logic                  load_ready;
    logic [N*T-1:0]        load_data;
    logic                  output_valid;
    logic                  output_ready;
    logic signed [T-1:0]   output_data;
    logic                  output_last;

    modport slave (
        input  load_valid,
        input  load_data,
        input  output_ready,
        output load_ready,
        output output_valid,
        output output_data,
        output output_last
    );

    modport master (
        output load_valid,
        output load_data,
        output output_ready,
        input  load_ready,
        input  output_valid,
        input  output_data,
        input  output_last
    );
endinterface

// File: rtl/vec_tx_8_16.sv
// Ping-pong vector-to-element serializer: accepts N*T-bit vectors, emits them
// one signed T-bit element per handshake, element 0 first, in load order.
module vec_tx_8_16 #(
    parameter int T = 16,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    vec_tx_8_16_if.slave   bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    logic [N*T-1:0] bank_q [2];
    logic           wp_q, wp_d;
    logic           rp_q, rp_d;
    logic [1:0]     occ_q, occ_d;
    logic [KW-1:0]  k_q, k_d;

    logic ld, pop, fin;

    // Handshakes are formed from registered occupancy only, so neither
    // ready nor valid has a combinational path from the other side.
    assign bus.load_ready   = (occ_q < 2'd2);
    assign bus.output_valid = (occ_q != 2'd0);
    assign bus.output_last  = bus.output_valid && (k_q == K_LAST);
    assign bus.output_data  = $signed(bank_q[rp_q][k_q*T +: T]);

    assign ld  = bus.load_valid && bus.load_ready;
    assign pop = bus.output_valid && bus.output_ready;
    assign fin = pop && (k_q == K_LAST);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        occ_d = occ_q;
        k_d   = k_q;
        if (ld) begin
            wp_d = ~wp_q;
        end
        if (pop) begin
            if (fin) begin
                k_d  = '0;
                rp_d = ~rp_q;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
        // Simultaneous load and final pop leave occupancy unchanged.
        if (ld && !fin) begin
            occ_d = occ_q + 2'd1;
        end else if (!ld && fin) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            occ_q <= 2'd0;
            k_q   <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
            k_q   <= k_d;
        end
    end

    // Bank contents are not reset; a reset clears occupancy, which hides them.
    always_ff @(posedge clk) begin
        if (ld) begin
            bank_q[wp_q] <= bus.load_data;
        end
    end
endmodule
